cam_pixel_capture: RTL and testbench

Downstream stage of the camera interface: samples the OV-style 8-bit parallel byte stream (vsync/href/data) on `pclk`, pairs consecutive bytes into RGB565 pixels, and issues one registered frame-buffer write per pixel with a linear raster address. Also tracks frame boundaries and flags malformed lines or frames for the display and control logic.

---
 rtl/cam_pixel_capture.sv | 152 +++++++++++++++
 tb/tb_cam_pixel_capture.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_pixel_capture.sv
// Camera byte-stream capture: pairs vsync/href-qualified bytes into RGB565 pixels,
// issues one frame-buffer write per pixel and reports line/frame integrity.
module cam_pixel_capture #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19
) (
    input  logic              i_pclk,
    input  logic              i_reset,
    input  logic              i_vsync,
    input  logic              i_href,
    input  logic [7:0]        i_d,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [15:0]       o_wr_data,
    output logic              o_frame_done,
    output logic              o_frame_ok,
    output logic              o_line_err
);
    localparam int PIX_TOTAL = H_RES * V_RES;
    localparam int X_W       = $clog2(H_RES + 2);
    localparam int Y_W       = $clog2(V_RES + 1);
    localparam int PIX_W     = $clog2(PIX_TOTAL + 1);

    localparam logic [X_W-1:0]   X_FULL   = X_W'(H_RES);
    localparam logic [X_W-1:0]   X_OVER   = X_W'(H_RES + 1);
    localparam logic [X_W-1:0]   X_ONE    = X_W'(1);
    localparam logic [Y_W-1:0]   Y_FULL   = Y_W'(V_RES);
    localparam logic [Y_W-1:0]   Y_ONE    = Y_W'(1);
    localparam logic [PIX_W-1:0] PIX_FULL = PIX_W'(PIX_TOTAL);
    localparam logic [PIX_W-1:0] PIX_ONE  = PIX_W'(1);

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        SYNC    = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_phase;
    logic             r_href_q;
    logic             r_bad;
    logic [7:0]       r_hi;
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic [PIX_W-1:0] r_pix;

    logic w_room;
    logic w_line_bad;

    assign w_room     = (r_pix < PIX_FULL);
    assign w_line_bad = (r_x != X_FULL) || r_phase;

    // Capture FSM, byte pairing, raster counters and registered outputs
    always_ff @(posedge i_pclk) begin
        if (i_reset) begin
            r_state      <= WAIT_VS;
            r_phase      <= 1'b0;
            r_href_q     <= 1'b0;
            r_bad        <= 1'b0;
            r_hi         <= 8'h00;
            r_x          <= '0;
            r_y          <= '0;
            r_pix        <= '0;
            o_wr_en      <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= 16'h0000;
            o_frame_done <= 1'b0;
            o_frame_ok   <= 1'b0;
            o_line_err   <= 1'b0;
        end else begin
            o_wr_en      <= 1'b0;
            o_frame_done <= 1'b0;
            case (r_state)
                WAIT_VS: begin
                    r_phase  <= 1'b0;
                    r_href_q <= 1'b0;
                    r_bad    <= 1'b0;
                    r_x      <= '0;
                    r_y      <= '0;
                    r_pix    <= '0;
                    if (i_vsync) begin
                        r_state <= SYNC;
                    end else begin
                        r_state <= WAIT_VS;
                    end
                end
                SYNC: begin
                    r_phase  <= 1'b0;
                    r_href_q <= 1'b0;
                    r_bad    <= 1'b0;
                    r_x      <= '0;
                    r_y      <= '0;
                    r_pix    <= '0;
                    if (!i_vsync) begin
                        r_state <= CAPTURE;
                    end else begin
                        r_state <= SYNC;
                    end
                end
                CAPTURE: begin
                    // vsync outranks href: a byte coincident with the rise is discarded
                    if (i_vsync) begin
                        o_frame_done <= 1'b1;
                        o_frame_ok   <= (r_pix == PIX_FULL) && (r_y == Y_FULL) && !r_bad;
                        r_phase      <= 1'b0;
                        r_href_q     <= 1'b0;
                        r_bad        <= 1'b0;
                        r_x          <= '0;
                        r_y          <= '0;
                        r_pix        <= '0;
                        r_state      <= SYNC;
                    end else if (i_href) begin
                        r_href_q <= 1'b1;
                        r_phase  <= ~r_phase;
                        if (!r_phase) begin
                            r_hi <= i_d;
                        end else if (w_room) begin
                            o_wr_en   <= 1'b1;
                            o_wr_addr <= ADDR_W'(r_pix);
                            o_wr_data <= {r_hi, i_d};
                            r_pix     <= r_pix + PIX_ONE;
                            // x saturates one past a full line so over-long lines still flag
                            r_x       <= (r_x == X_OVER) ? r_x : (r_x + X_ONE);
                        end else begin
                            r_bad <= 1'b1;
                        end
                    end else begin
                        r_href_q <= 1'b0;
                        r_phase  <= 1'b0;
                        if (r_href_q) begin
                            if (w_line_bad) begin
                                o_line_err <= 1'b1;
                                r_bad      <= 1'b1;
                            end else begin
                                r_bad <= r_bad;
                            end
                            r_x <= '0;
                            r_y <= (r_y == Y_FULL) ? r_y : (r_y + Y_ONE);
                        end else begin
                            r_x <= r_x;
                        end
                    end
                end
                default: begin
                    r_state <= WAIT_VS;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Self-checking bench for cam_pixel_capture on a 4x2 frame: directed scenarios
// plus randomized frames scored against a line-level behavioural model.
module tb_cam_pixel_capture;
    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = 3;

    logic          pclk = 1'b0;
    logic          reset;
    logic          vsync;
    logic          href;
    logic [7:0]    d;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          frame_done;
    logic          frame_ok;
    logic          line_err;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t  obs_q[$];
    wr_t  exp_q[$];
    int   done_cnt = 0;
    logic done_ok  = 1'b0;

    // model state
    int m_pix  = 0;
    int m_y    = 0;
    bit m_bad  = 1'b0;
    bit m_lerr = 1'b0;
    int seqb   = 0;

    always #5 pclk = ~pclk;

    cam_pixel_capture #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
        .i_pclk      (pclk),
        .i_reset     (reset),
        .i_vsync     (vsync),
        .i_href      (href),
        .i_d         (d),
        .o_wr_en     (wr_en),
        .o_wr_addr   (wr_addr),
        .o_wr_data   (wr_data),
        .o_frame_done(frame_done),
        .o_frame_ok  (frame_ok),
        .o_line_err  (line_err)
    );

    // collect writes and frame_done pulses just after each active edge
    always @(posedge pclk) begin
        wr_t w;
        #1;
        if (wr_en === 1'b1) begin
            w.addr = int'(wr_addr);
            w.data = int'(wr_data);
            obs_q.push_back(w);
        end
        if (frame_done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_ok  = frame_ok;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic drive_line(input int nb, input bit seq);
        logic [7:0] b[$];
        int x;
        wr_t w;
        x = 0;
        for (int i = 0; i < nb; i++) begin
            @(negedge pclk);
            href = 1'b1;
            if (seq) begin
                d = 8'(seqb);
                seqb++;
            end else begin
                d = 8'($urandom);
            end
            b.push_back(d);
        end
        @(negedge pclk);
        href = 1'b0;
        for (int k = 0; k + 1 < nb; k += 2) begin
            if (m_pix < H * V) begin
                w.addr = m_pix;
                w.data = int'({b[k], b[k+1]});
                exp_q.push_back(w);
                m_pix++;
                x++;
            end else begin
                m_bad = 1'b1;
            end
        end
        if (x != H || (nb % 2) != 0) begin
            m_lerr = 1'b1;
            m_bad  = 1'b1;
        end
        if (m_y < V) m_y++;
        tick(2);
        check("line_err after line", line_err, m_lerr);
    endtask

    task automatic compare_writes(input string tag);
        int n;
        check({tag, " write count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s addr[%0d]", tag, i), obs_q[i].addr, exp_q[i].addr);
            check($sformatf("%s data[%0d]", tag, i), obs_q[i].data, exp_q[i].data);
        end
    endtask

    // assumes vsync is already high and the DUT is in sync
    task automatic frame(input string tag, input int nl, input int l0, input int l1,
                         input int l2, input bit seq);
        int nbs[3];
        int d0;
        bit ok;
        nbs[0] = l0;
        nbs[1] = l1;
        nbs[2] = l2;
        @(negedge pclk);
        vsync = 1'b0;
        tick(2);
        for (int i = 0; i < nl; i++) drive_line(nbs[i], seq);
        ok = (m_pix == H * V) && (m_y == V) && !m_bad;
        d0 = done_cnt;
        @(negedge pclk);
        vsync = 1'b1;
        tick(3);
        check({tag, " frame_done count"}, done_cnt - d0, 1);
        check({tag, " frame_ok"}, done_ok, ok);
        compare_writes(tag);
        if (exp_q.size() > 0) begin
            check({tag, " addr hold"}, wr_addr, exp_q[exp_q.size()-1].addr);
            check({tag, " data hold"}, wr_data, exp_q[exp_q.size()-1].data);
        end
        obs_q.delete();
        exp_q.delete();
        m_pix = 0;
        m_y   = 0;
        m_bad = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge pclk);
        reset = 1'b1;
        href  = 1'b0;
        vsync = 1'b0;
        tick(2);
        reset  = 1'b0;
        m_lerr = 1'b0;
        vsync  = 1'b1;
        tick(3);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int d0;
        int nl;
        int nb[3];
        reset = 1'b1;
        vsync = 1'b0;
        href  = 1'b0;
        d     = 8'h00;
        tick(3);
        check("reset wr_en", wr_en, 0);
        check("reset wr_addr", wr_addr, 0);
        check("reset wr_data", wr_data, 0);
        check("reset frame_done", frame_done, 0);
        check("reset frame_ok", frame_ok, 0);
        check("reset line_err", line_err, 0);

        // start-up: leave reset mid-line with vsync low; nothing may be captured
        for (int i = 0; i < 20; i++) begin
            @(negedge pclk);
            if (i == 3) reset = 1'b0;
            href = ((i % 10) != 9);
            d    = 8'($urandom);
        end
        @(negedge pclk);
        href = 1'b0;
        tick(3);
        check("startup no writes", obs_q.size(), 0);
        check("startup line_err", line_err, 0);
        vsync = 1'b1;
        tick(3);
        check("startup no frame_done", done_cnt, 0);

        seqb = 0;
        frame("nominal", 2, 8, 8, 0, 1'b1);
        check("nominal line_err", line_err, 0);

        do_reset();
        frame("short", 2, 6, 8, 0, 1'b0);

        do_reset();
        frame("odd", 2, 9, 8, 0, 1'b0);

        do_reset();
        frame("overflow", 3, 8, 8, 8, 1'b0);

        // reset after three writes of a line
        do_reset();
        @(negedge pclk);
        vsync = 1'b0;
        tick(2);
        for (int i = 0; i < 6; i++) begin
            @(negedge pclk);
            href = 1'b1;
            d    = 8'(8'h40 + i);
        end
        d0 = done_cnt;
        @(negedge pclk);
        reset = 1'b1;
        d     = 8'h99;
        @(negedge pclk);
        check("midrst wr_en", wr_en, 0);
        check("midrst wr_addr", wr_addr, 0);
        check("midrst wr_data", wr_data, 0);
        check("midrst frame_done", frame_done, 0);
        check("midrst frame_ok", frame_ok, 0);
        check("midrst line_err", line_err, 0);
        check("midrst write count", obs_q.size(), 3);
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            check($sformatf("midrst addr[%0d]", i), obs_q[i].addr, i);
            check($sformatf("midrst data[%0d]", i), obs_q[i].data,
                  ((8'h40 + 2 * i) << 8) | (8'h41 + 2 * i));
        end
        obs_q.delete();
        m_lerr = 1'b0;
        reset  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            d = 8'($urandom);
        end
        @(negedge pclk);
        href  = 1'b0;
        vsync = 1'b1;
        tick(3);
        check("midrst no frame_done", done_cnt - d0, 0);
        check("midrst no writes after reset", obs_q.size(), 0);
        frame("after reset", 2, 8, 8, 0, 1'b0);

        // randomized frames
        for (int f = 0; f < 8; f++) begin
            nl = $urandom_range(1, 3);
            for (int i = 0; i < 3; i++) begin
                nb[i] = ($urandom_range(0, 1) != 0) ? 8 : $urandom_range(5, 11);
            end
            frame($sformatf("rand%0d", f), nl, nb[0], nb[1], nb[2], 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
